// File: rtl/serv_ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encodings,
// the default boot address and the width of the ack timeout counter.
package serv_ifetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    IDLE = 2'b01,
    WAIT = 2'b10
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Large enough for the full legal ACK_TIMEOUT range of 0..255.
  localparam int TMO_CNT_W = 8;

endpackage

// File: rtl/serv_pc_deser.sv
// Serial-to-parallel PC assembler. The control path streams the next PC
// LSB first. After 32 bits have arrived, the word is flagged ready.
// A capture by the fetch FSM restarts the bit count.
module serv_pc_deser
  import serv_ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_pc_en,
  input  logic        i_pc_bit,
  input  logic        i_capture,
  output logic [31:0] o_pc,
  output logic        o_pc_ready
);

  logic [31:0] pc_sr;
  logic [4:0]  bitcnt;
  logic        pc_ready;

  // Shift the incoming bit in from the top and track how many bits form the next PC.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_sr    <= RESET_PC;
      bitcnt   <= 5'd0;
      pc_ready <= 1'b1;
    end else begin
      if (i_pc_en) begin
        pc_sr <= {i_pc_bit, pc_sr[31:1]};
      end
      if (i_capture) begin
        bitcnt   <= i_pc_en ? 5'd1 : 5'd0;
        pc_ready <= 1'b0;
      end else if (i_pc_en) begin
        bitcnt <= bitcnt + 5'd1;
        if (bitcnt == 5'd31) begin
          pc_ready <= 1'b1;
        end
      end
    end
  end

  assign o_pc       = pc_sr;
  assign o_pc_ready = pc_ready;

endmodule

// File: rtl/serv_ifetch.sv
// Wishbone instruction-bus initiator. Boots from RESET_PC, then fetches
// whatever PC the serial stream has assembled each time i_fetch is pulsed.
// Each fetched word is handed to decode as a one-cycle strobe. An optional
// ack timeout aborts a stuck read and reports it on o_bus_err.
module serv_ifetch
  import serv_ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned ACK_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_pc_en,
  input  logic        i_pc_bit,
  input  logic        i_fetch,
  output logic        o_pc_ready,
  output logic        o_busy,
  output logic [31:0] o_ibus_adr,
  output logic        o_ibus_cyc,
  input  logic [31:0] i_ibus_rdt,
  input  logic        i_ibus_ack,
  output logic        o_wb_en,
  output logic [31:0] o_wb_rdt,
  output logic        o_bus_err
);

  localparam bit TMO_EN = (ACK_TIMEOUT != 0);
  localparam logic [TMO_CNT_W-1:0] TMO_LAST =
    TMO_EN ? TMO_CNT_W'(ACK_TIMEOUT - 1) : '0;

  fetch_state_e         state_q, state_d;
  logic [31:2]          adr_q, adr_d;
  logic                 cyc_q, cyc_d;
  logic                 wb_en_q, wb_en_d;
  logic [31:0]          rdt_q, rdt_d;
  logic                 err_q, err_d;
  logic [TMO_CNT_W-1:0] tmo_q, tmo_d;
  logic                 capture;
  logic [31:0]          pc_word;

  serv_pc_deser #(
    .RESET_PC (RESET_PC)
  ) u_pc_deser (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_pc_en    (i_pc_en),
    .i_pc_bit   (i_pc_bit),
    .i_capture  (capture),
    .o_pc       (pc_word),
    .o_pc_ready (o_pc_ready)
  );

  // The bus address is word aligned, so the two low PC bits are dropped here.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^pc_word[1:0];

  // Register the FSM state and all bus/decode-facing outputs; reset drops cyc at once.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= BOOT;
      adr_q   <= RESET_PC[31:2];
      cyc_q   <= 1'b0;
      wb_en_q <= 1'b0;
      rdt_q   <= 32'h0000_0000;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      cyc_q   <= cyc_d;
      wb_en_q <= wb_en_d;
      rdt_q   <= rdt_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic: launch boot/requested reads, then finish each one on ack or timeout.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    cyc_d   = cyc_q;
    wb_en_d = 1'b0;
    rdt_d   = rdt_q;
    err_d   = 1'b0;
    tmo_d   = tmo_q;
    capture = 1'b0;
    case (state_q)
      BOOT: begin
        cyc_d   = 1'b1;
        tmo_d   = '0;
        state_d = WAIT;
      end
      IDLE: begin
        if (i_fetch) begin
          adr_d   = pc_word[31:2];
          capture = 1'b1;
          cyc_d   = 1'b1;
          tmo_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (i_ibus_ack) begin
          rdt_d   = i_ibus_rdt;
          wb_en_d = 1'b1;
          cyc_d   = 1'b0;
          state_d = IDLE;
        end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_CNT_W'(1);
        end
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign o_busy     = (state_q != IDLE);
  assign o_ibus_adr = {adr_q, 2'b00};
  assign o_ibus_cyc = cyc_q;
  assign o_wb_en    = wb_en_q;
  assign o_wb_rdt   = rdt_q;
  assign o_bus_err  = err_q;

endmodule

// File: tb/tb_serv_ifetch.sv
// Directed testbench for serv_ifetch. Inputs are driven on the falling edge,
// and outputs are sampled there as well.
module tb_serv_ifetch;

  localparam logic [31:0] BOOT_PC = 32'h0000_1000;

  logic        clk;
  logic        i_rst_n;
  logic        i_pc_en;
  logic        i_pc_bit;
  logic        i_fetch;
  logic        o_pc_ready;
  logic        o_busy;
  logic [31:0] o_ibus_adr;
  logic        o_ibus_cyc;
  logic [31:0] i_ibus_rdt;
  logic        i_ibus_ack;
  logic        o_wb_en;
  logic [31:0] o_wb_rdt;
  logic        o_bus_err;

  int errors = 0;
  int checks = 0;

  serv_ifetch #(
    .RESET_PC    (BOOT_PC),
    .ACK_TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_pc_en    (i_pc_en),
    .i_pc_bit   (i_pc_bit),
    .i_fetch    (i_fetch),
    .o_pc_ready (o_pc_ready),
    .o_busy     (o_busy),
    .o_ibus_adr (o_ibus_adr),
    .o_ibus_cyc (o_ibus_cyc),
    .i_ibus_rdt (i_ibus_rdt),
    .i_ibus_ack (i_ibus_ack),
    .o_wb_en    (o_wb_en),
    .o_wb_rdt   (o_wb_rdt),
    .o_bus_err  (o_bus_err)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic shift_bits(input logic [31:0] w, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      i_pc_en  = 1'b1;
      i_pc_bit = w[i];
      @(negedge clk);
    end
    i_pc_en  = 1'b0;
    i_pc_bit = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b1;
    #1 i_rst_n = 1'b0;
    @(negedge clk);
    checks++; if (o_ibus_cyc !== 1'b0) begin errors++; $display("[TB] FAIL reset_cyc: got %b want 0", o_ibus_cyc); end
    checks++; if (o_wb_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_en: got %b want 0", o_wb_en); end
    checks++; if (o_wb_rdt !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdt: got %h want 0", o_wb_rdt); end
    checks++; if (o_bus_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b want 0", o_bus_err); end
    checks++; if (o_pc_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_pc_ready: got %b want 1", o_pc_ready); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_busy: got %b want 1", o_busy); end
    checks++; if (o_ibus_adr !== BOOT_PC) begin errors++; $display("[TB] FAIL reset_adr: got %h want %h", o_ibus_adr, BOOT_PC); end
    @(negedge clk);
  endtask

  task automatic test_boot();
    i_rst_n = 1'b1;
    @(negedge clk);
    checks++; if (o_ibus_cyc !== 1'b1) begin errors++; $display("[TB] FAIL boot_cyc: got %b want 1", o_ibus_cyc); end
    checks++; if (o_ibus_adr !== BOOT_PC) begin errors++; $display("[TB] FAIL boot_adr: got %h want %h", o_ibus_adr, BOOT_PC); end
    checks++; if (o_wb_en !== 1'b0) begin errors++; $display("[TB] FAIL boot_early_wb_en: got %b want 0", o_wb_en); end
    @(negedge clk);
    checks++; if (o_wb_en !== 1'b0) begin errors++; $display("[TB] FAIL boot_wait_wb_en: got %b want 0", o_wb_en); end
    i_ibus_ack = 1'b1;
    i_ibus_rdt = 32'h0000_0513;
    @(negedge clk);
    i_ibus_ack = 1'b0;
    checks++; if (o_wb_en !== 1'b1) begin errors++; $display("[TB] FAIL boot_wb_en: got %b want 1", o_wb_en); end
    checks++; if (o_wb_rdt !== 32'h0000_0513) begin errors++; $display("[TB] FAIL boot_rdt: got %h want 00000513", o_wb_rdt); end
    checks++; if (o_ibus_cyc !== 1'b0) begin errors++; $display("[TB] FAIL boot_cyc_drop: got %b want 0", o_ibus_cyc); end
    @(negedge clk);
    checks++; if (o_wb_en !== 1'b0) begin errors++; $display("[TB] FAIL boot_wb_en_pulse: got %b want 0", o_wb_en); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL boot_idle: got busy=%b want 0", o_busy); end
  endtask

  task automatic test_serial_pc();
    shift_bits(32'h0000_0104, 0, 31);
    checks++; if (o_pc_ready !== 1'b1) begin errors++; $display("[TB] FAIL serial_ready: got %b want 1", o_pc_ready); end
    i_fetch = 1'b1;
    @(negedge clk);
    i_fetch = 1'b0;
    checks++; if (o_ibus_adr !== 32'h0000_0104) begin errors++; $display("[TB] FAIL serial_adr: got %h want 00000104", o_ibus_adr); end
    checks++; if (o_pc_ready !== 1'b0) begin errors++; $display("[TB] FAIL serial_ready_clr: got %b want 0", o_pc_ready); end
    checks++; if (o_ibus_cyc !== 1'b1) begin errors++; $display("[TB] FAIL serial_cyc: got %b want 1", o_ibus_cyc); end
    checks++; if (o_wb_en !== 1'b0) begin errors++; $display("[TB] FAIL serial_early_wb_en: got %b want 0", o_wb_en); end
    i_ibus_ack = 1'b1;
    i_ibus_rdt = 32'h00A0_0093;
    @(negedge clk);
    i_ibus_ack = 1'b0;
    checks++; if (o_wb_en !== 1'b1) begin errors++; $display("[TB] FAIL serial_wb_en: got %b want 1", o_wb_en); end
    checks++; if (o_wb_rdt !== 32'h00A0_0093) begin errors++; $display("[TB] FAIL serial_rdt: got %h want 00a00093", o_wb_rdt); end
    checks++; if (o_ibus_cyc !== 1'b0) begin errors++; $display("[TB] FAIL serial_cyc_drop: got %b want 0", o_ibus_cyc); end
    @(negedge clk);
    checks++; if (o_wb_en !== 1'b0) begin errors++; $display("[TB] FAIL serial_wb_en_pulse: got %b want 0", o_wb_en); end
    checks++; if (o_wb_rdt !== 32'h00A0_0093) begin errors++; $display("[TB] FAIL serial_rdt_hold: got %h want 00a00093", o_wb_rdt); end
  endtask

  task automatic test_low_bits();
    shift_bits(32'h0000_0107, 0, 30);
    checks++; if (o_pc_ready !== 1'b0) begin errors++; $display("[TB] FAIL low_ready_31: got %b want 0", o_pc_ready); end
    shift_bits(32'h0000_0107, 31, 31);
    checks++; if (o_pc_ready !== 1'b1) begin errors++; $display("[TB] FAIL low_ready_32: got %b want 1", o_pc_ready); end
    i_fetch = 1'b1;
    @(negedge clk);
    i_fetch = 1'b0;
    checks++; if (o_ibus_adr !== 32'h0000_0104) begin errors++; $display("[TB] FAIL low_adr: got %h want 00000104", o_ibus_adr); end
    i_ibus_ack = 1'b1;
    i_ibus_rdt = 32'h00C5_8533;
    @(negedge clk);
    i_ibus_ack = 1'b0;
    checks++; if (o_wb_rdt !== 32'h00C5_8533) begin errors++; $display("[TB] FAIL low_rdt: got %h want 00c58533", o_wb_rdt); end
    @(negedge clk);
  endtask

  task automatic test_busy_request();
    int wb_cnt;
    int cyc_cnt;
    i_fetch = 1'b1;
    @(negedge clk);
    checks++; if (o_ibus_adr !== 32'h0000_0104) begin errors++; $display("[TB] FAIL busy_adr_start: got %h want 00000104", o_ibus_adr); end
    i_pc_en  = 1'b1;
    i_pc_bit = 1'b1;
    @(negedge clk);
    i_pc_en  = 1'b0;
    i_pc_bit = 1'b0;
    checks++; if (o_ibus_adr !== 32'h0000_0104) begin errors++; $display("[TB] FAIL busy_adr_hold: got %h want 00000104", o_ibus_adr); end
    checks++; if (o_ibus_cyc !== 1'b1) begin errors++; $display("[TB] FAIL busy_cyc: got %b want 1", o_ibus_cyc); end
    i_ibus_ack = 1'b1;
    i_ibus_rdt = 32'h1234_5678;
    @(negedge clk);
    i_ibus_ack = 1'b0;
    i_fetch    = 1'b0;
    wb_cnt  = (o_wb_en === 1'b1) ? 1 : 0;
    cyc_cnt = 0;
    checks++; if (o_ibus_cyc !== 1'b0) begin errors++; $display("[TB] FAIL busy_cyc_drop: got %b want 0", o_ibus_cyc); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (o_wb_en === 1'b1) wb_cnt++;
      if (o_ibus_cyc === 1'b1) cyc_cnt++;
    end
    checks++; if (wb_cnt !== 1) begin errors++; $display("[TB] FAIL busy_wb_en_count: got %0d want 1", wb_cnt); end
    checks++; if (cyc_cnt !== 0) begin errors++; $display("[TB] FAIL busy_extra_cycle: got %0d cyc cycles want 0", cyc_cnt); end
    checks++; if (o_wb_rdt !== 32'h1234_5678) begin errors++; $display("[TB] FAIL busy_rdt: got %h want 12345678", o_wb_rdt); end
  endtask

  task automatic test_timeout();
    int cyc_cnt;
    int err_cnt;
    int wb_cnt;
    int err_idx;
    // Scenario A: no ack at all
    i_fetch = 1'b1;
    @(negedge clk);
    i_fetch = 1'b0;
    cyc_cnt = 0; err_cnt = 0; wb_cnt = 0; err_idx = -1;
    for (int k = 0; k < 8; k++) begin
      if (o_ibus_cyc === 1'b1) cyc_cnt++;
      if (o_bus_err === 1'b1) begin err_cnt++; if (err_idx < 0) err_idx = k; end
      if (o_wb_en === 1'b1) wb_cnt++;
      @(negedge clk);
    end
    checks++; if (cyc_cnt !== 4) begin errors++; $display("[TB] FAIL tmo_cyc_len: got %0d want 4", cyc_cnt); end
    checks++; if (err_cnt !== 1) begin errors++; $display("[TB] FAIL tmo_err_count: got %0d want 1", err_cnt); end
    checks++; if (err_idx !== 4) begin errors++; $display("[TB] FAIL tmo_err_cycle: got %0d want 4", err_idx); end
    checks++; if (wb_cnt !== 0) begin errors++; $display("[TB] FAIL tmo_wb_en: got %0d want 0", wb_cnt); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL tmo_idle: got busy=%b want 0", o_busy); end
    // Scenario B: ack lands in the expiry cycle
    i_fetch = 1'b1;
    @(negedge clk);
    i_fetch = 1'b0;
    cyc_cnt = 0; err_cnt = 0; wb_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (o_ibus_cyc === 1'b1) cyc_cnt++;
      if (o_bus_err === 1'b1) err_cnt++;
      if (o_wb_en === 1'b1) wb_cnt++;
      i_ibus_ack = (k == 3);
      i_ibus_rdt = 32'hFFF0_0113;
      @(negedge clk);
    end
    i_ibus_ack = 1'b0;
    checks++; if (cyc_cnt !== 4) begin errors++; $display("[TB] FAIL tmo_ack_cyc_len: got %0d want 4", cyc_cnt); end
    checks++; if (err_cnt !== 0) begin errors++; $display("[TB] FAIL tmo_ack_err: got %0d want 0", err_cnt); end
    checks++; if (wb_cnt !== 1) begin errors++; $display("[TB] FAIL tmo_ack_wb_en: got %0d want 1", wb_cnt); end
    checks++; if (o_wb_rdt !== 32'hFFF0_0113) begin errors++; $display("[TB] FAIL tmo_ack_rdt: got %h want fff00113", o_wb_rdt); end
  endtask

  task automatic test_async_reset();
    int wb_cnt;
    i_fetch = 1'b1;
    @(negedge clk);
    i_fetch = 1'b0;
    checks++; if (o_ibus_cyc !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre_cyc: got %b want 1", o_ibus_cyc); end
    i_ibus_ack = 1'b1;
    i_ibus_rdt = 32'hBAD0_BAD0;
    #2 i_rst_n = 1'b0;
    #1;
    checks++; if (o_ibus_cyc !== 1'b0) begin errors++; $display("[TB] FAIL arst_cyc_async: got %b want 0", o_ibus_cyc); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("[TB] FAIL arst_busy: got %b want 1", o_busy); end
    wb_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (o_wb_en === 1'b1) wb_cnt++;
    end
    i_ibus_ack = 1'b0;
    i_rst_n = 1'b1;
    @(negedge clk);
    if (o_wb_en === 1'b1) wb_cnt++;
    checks++; if (wb_cnt !== 0) begin errors++; $display("[TB] FAIL arst_wb_en: got %0d pulses want 0", wb_cnt); end
    checks++; if (o_wb_rdt !== 32'h0) begin errors++; $display("[TB] FAIL arst_rdt: got %h want 0", o_wb_rdt); end
    checks++; if (o_ibus_cyc !== 1'b1) begin errors++; $display("[TB] FAIL arst_boot_cyc: got %b want 1", o_ibus_cyc); end
    checks++; if (o_ibus_adr !== BOOT_PC) begin errors++; $display("[TB] FAIL arst_boot_adr: got %h want %h", o_ibus_adr, BOOT_PC); end
    checks++; if (o_pc_ready !== 1'b1) begin errors++; $display("[TB] FAIL arst_pc_ready: got %b want 1", o_pc_ready); end
    i_ibus_ack = 1'b1;
    i_ibus_rdt = 32'h0000_0513;
    @(negedge clk);
    i_ibus_ack = 1'b0;
    checks++; if (o_wb_en !== 1'b1) begin errors++; $display("[TB] FAIL arst_boot_wb_en: got %b want 1", o_wb_en); end
    checks++; if (o_wb_rdt !== 32'h0000_0513) begin errors++; $display("[TB] FAIL arst_boot_rdt: got %h want 00000513", o_wb_rdt); end
    @(negedge clk);
  endtask

  // Test sequence
  initial begin
    i_rst_n    = 1'b1;
    i_pc_en    = 1'b0;
    i_pc_bit   = 1'b0;
    i_fetch    = 1'b0;
    i_ibus_rdt = 32'h0;
    i_ibus_ack = 1'b0;
    $display("[TB] starting serv_ifetch tests");
    test_reset();
    test_boot();
    test_serial_pc();
    test_low_bits();
    test_busy_request();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
